lif_neuron_step: RTL and testbench

//  Sequential leaky integrate-and-fire neuron. Consumes one synaptic current sample per timestep
//  and performs one forward-Euler membrane update using the combinational add/mult/fixed_point_cmp ops.
//  It emits the new membrane voltage and a spike flag, and applies a refractory period after each spike.
//  It sits downstream of the synaptic-current stage and upstream of the spike router.

---
 rtl/snn_fixed_pkg.sv | 43 ++++
 rtl/lif_neuron_step_ops.sv | 79 +++++++
 rtl/lif_neuron_step.sv | 134 +++++++++++++
 tb/tb_lif_neuron_step.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/snn_fixed_pkg.sv
// Shared sign-magnitude fixed-point types, constants and helpers for the LIF neuron datapath.
package snn_fixed_pkg;

   localparam int N     = 32;
   localparam int Q     = 16;
   localparam int CNT_W = 8;

   localparam logic [N-1:0] FP_ONE  = 32'h0001_0000;
   localparam logic [N-1:0] FP_ZERO = 32'h0000_0000;

   localparam logic [N-1:0]     V_REST_DEF       = 32'h8041_0000;
   localparam logic [N-1:0]     V_TH_DEF         = 32'h8032_0000;
   localparam logic [N-1:0]     V_RESET_DEF      = 32'h804B_0000;
   localparam logic [N-1:0]     K_LEAK_DEF       = 32'h0000_8000;
   localparam logic [N-1:0]     K_IN_DEF         = 32'h0001_0000;
   localparam logic [CNT_W-1:0] REFRAC_STEPS_DEF = 8'd2;

   // state     | meaning
   // S_IDLE    | waiting for a current sample, in_ready high
   // S_LEAK    | leak term K_LEAK*(V_REST - v) registered
   // S_INTEG   | candidate voltage v + leak + K_IN*i registered
   // S_CHECK   | threshold / refractory decision, result registered
   // S_DONE    | result held until the consumer takes it
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAK,
      S_INTEG,
      S_CHECK,
      S_DONE
   } lif_state_t;

   function automatic logic is_neg_zero(input logic [N-1:0] x);
      return x[N-1] && (x[N-2:0] == '0);
   endfunction

   function automatic logic [N-1:0] negate(input logic [N-1:0] x);
      logic [N-1:0] r;
      r = {~x[N-1], x[N-2:0]};
      if (is_neg_zero(r)) r = FP_ZERO;
      return r;
   endfunction

endpackage

// File: rtl/lif_neuron_step_ops.sv
// Combinational sign-magnitude operators: carry-dropping add, magnitude-truncating multiply, compare.
module add #(
   parameter int N = 32
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] sum_o
);
   logic [N-2:0] mag_a, mag_b, mag_r;
   logic         sgn_r;

   assign mag_a = a_i[N-2:0];
   assign mag_b = b_i[N-2:0];

   always_comb begin
      mag_r = '0;
      sgn_r = 1'b0;
      if (a_i[N-1] == b_i[N-1]) begin
         mag_r = mag_a + mag_b;
         sgn_r = a_i[N-1];
      end else if (mag_a >= mag_b) begin
         mag_r = mag_a - mag_b;
         sgn_r = a_i[N-1];
      end else begin
         mag_r = mag_b - mag_a;
         sgn_r = b_i[N-1];
      end
      // a cancelled sum is always reported as +0
      if (mag_r == '0) sgn_r = 1'b0;
   end

   assign sum_o = {sgn_r, mag_r};
endmodule

module mult #(
   parameter int N = 32,
   parameter int Q = 16
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] p_o
);
   logic [2*N-3:0] prod;
   logic [N-2:0]   mag;

   assign prod = a_i[N-2:0] * b_i[N-2:0];
   assign mag  = (N-1)'(prod >> Q);
   assign p_o  = {(a_i[N-1] ^ b_i[N-1]) && (mag != '0), mag};
endmodule

module fixed_point_cmp #(
   parameter int N = 32
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         gt_o,
   output logic         eq_o
);
   logic a_zero, b_zero;

   assign a_zero = (a_i[N-2:0] == '0);
   assign b_zero = (b_i[N-2:0] == '0);

   always_comb begin
      gt_o = 1'b0;
      eq_o = 1'b0;
      if (a_zero && b_zero) begin
         eq_o = 1'b1;
      end else if (a_i[N-1] != b_i[N-1]) begin
         gt_o = ~a_i[N-1];
      end else if (a_i[N-2:0] == b_i[N-2:0]) begin
         eq_o = 1'b1;
      end else if (a_i[N-1]) begin
         gt_o = (a_i[N-2:0] < b_i[N-2:0]);
      end else begin
         gt_o = (a_i[N-2:0] > b_i[N-2:0]);
      end
   end
endmodule

// File: rtl/lif_neuron_step.sv
// Leaky integrate-and-fire neuron: one forward-Euler membrane update per accepted current sample,
// with spike detection and a refractory clamp.
module lif_neuron_step
   import snn_fixed_pkg::*;
#(
   parameter logic [N-1:0]     V_REST       = V_REST_DEF,
   parameter logic [N-1:0]     V_TH         = V_TH_DEF,
   parameter logic [N-1:0]     V_RESET      = V_RESET_DEF,
   parameter logic [N-1:0]     K_LEAK       = K_LEAK_DEF,
   parameter logic [N-1:0]     K_IN         = K_IN_DEF,
   parameter logic [CNT_W-1:0] REFRAC_STEPS = REFRAC_STEPS_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] i_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] v_out,
   output logic         spike,
   output logic         refrac
);
   lif_state_t       state_q, state_d;
   logic [N-1:0]     v_q, v_d;
   logic [N-1:0]     i_r_q, i_r_d;
   logic [N-1:0]     leak_q, leak_d;
   logic [N-1:0]     vn_q, vn_d;
   logic [N-1:0]     v_out_q, v_out_d;
   logic             spike_q, spike_d;
   logic             out_valid_q, out_valid_d;
   logic             refrac_q, refrac_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [N-1:0] neg_v, diff, leak_prod, in_prod, acc0, acc1;
   logic         th_gt, th_eq;

   assign neg_v = negate(v_q);

   add  #(.N(N))         u_add_diff  (.a_i(V_REST), .b_i(neg_v),     .sum_o(diff));
   mult #(.N(N), .Q(Q))  u_mult_leak (.a_i(K_LEAK), .b_i(diff),      .p_o(leak_prod));
   mult #(.N(N), .Q(Q))  u_mult_in   (.a_i(K_IN),   .b_i(i_r_q),     .p_o(in_prod));
   add  #(.N(N))         u_add_acc0  (.a_i(v_q),    .b_i(leak_q),    .sum_o(acc0));
   add  #(.N(N))         u_add_acc1  (.a_i(acc0),   .b_i(in_prod),   .sum_o(acc1));
   fixed_point_cmp #(.N(N)) u_cmp_th (.a_i(vn_q),   .b_i(V_TH),      .gt_o(th_gt), .eq_o(th_eq));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         v_q         <= V_REST;
         i_r_q       <= FP_ZERO;
         leak_q      <= FP_ZERO;
         vn_q        <= FP_ZERO;
         v_out_q     <= V_REST;
         spike_q     <= 1'b0;
         out_valid_q <= 1'b0;
         refrac_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         i_r_q       <= i_r_d;
         leak_q      <= leak_d;
         vn_q        <= vn_d;
         v_out_q     <= v_out_d;
         spike_q     <= spike_d;
         out_valid_q <= out_valid_d;
         refrac_q    <= refrac_d;
         count_q     <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      i_r_d       = i_r_q;
      leak_d      = leak_q;
      vn_d        = vn_q;
      v_out_d     = v_out_q;
      spike_d     = spike_q;
      out_valid_d = out_valid_q;
      refrac_d    = refrac_q;
      count_d     = count_q;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               i_r_d   = i_in;
               state_d = S_LEAK;
            end
         end
         S_LEAK: begin
            leak_d  = leak_prod;
            state_d = S_INTEG;
         end
         S_INTEG: begin
            vn_d    = acc1;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (count_q != '0) begin
               // refractory: the integrated value is computed but thrown away
               v_d     = V_RESET;
               spike_d = 1'b0;
               count_d = count_q - 1'b1;
            end else if (th_gt || th_eq) begin
               v_d     = V_RESET;
               spike_d = 1'b1;
               count_d = REFRAC_STEPS;
            end else begin
               v_d     = vn_q;
               spike_d = 1'b0;
            end
            v_out_d     = v_d;
            refrac_d    = (count_d != '0);
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign v_out     = v_out_q;
   assign spike     = spike_q;
   assign refrac    = refrac_q;
endmodule

// File: tb/tb_lif_neuron_step.sv
// Directed and randomized checks of lif_neuron_step against an integer-arithmetic neuron model.
module tb_lif_neuron_step;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] i_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] v_out;
   logic        spike;
   logic        refrac;

   int checks = 0;
   int errors = 0;

   // model state, in units of 2^-16
   longint v_m;
   int     cnt_m;
   logic   spk_m;

   localparam longint ONE      = 65536;
   localparam longint V_REST_I = -65 * ONE;
   localparam longint V_TH_I   = -50 * ONE;
   localparam longint V_RST_I  = -75 * ONE;

   lif_neuron_step dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .i_in(i_in),
      .out_valid(out_valid), .out_ready(out_ready), .v_out(v_out), .spike(spike), .refrac(refrac)
   );

   always #5 clk = ~clk;

   function automatic longint sm2i(input logic [31:0] x);
      longint m;
      m = longint'(x[30:0]);
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] i2sm(input longint x);
      logic [31:0] r;
      if (x < 0) r = {1'b1, 31'(-x)};
      else       r = {1'b0, 31'(x)};
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic [31:0] iv);
      longint leak, vn;
      if (cnt_m == 0) begin
         leak = ((V_REST_I - v_m) * 32768) / ONE;
         vn   = v_m + leak + sm2i(iv);
         if (vn >= V_TH_I) begin
            v_m = V_RST_I; spk_m = 1'b1; cnt_m = 2;
         end else begin
            v_m = vn; spk_m = 1'b0;
         end
      end else begin
         v_m = V_RST_I; spk_m = 1'b0; cnt_m--;
      end
   endtask

   task automatic run_step(input logic [31:0] iv, input int stall, input string tag);
      int lat;
      logic [31:0] held;
      model_step(iv);
      @(negedge clk);
      chk({tag, ".in_ready"}, in_ready, 1);
      in_valid  = 1'b1;
      i_in      = iv;
      out_ready = (stall == 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      i_in     = $urandom;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, lat, 3);
      chk({tag, ".v_out"}, v_out, i2sm(v_m));
      chk({tag, ".spike"}, spike, spk_m);
      chk({tag, ".refrac"}, refrac, cnt_m != 0);
      held = v_out;
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         i_in     = $urandom;
         @(posedge clk); #1;
         chk({tag, ".stall_valid"}, out_valid, 1);
         chk({tag, ".stall_v"}, v_out, held);
         chk({tag, ".stall_spike"}, spike, spk_m);
         chk({tag, ".stall_in_ready"}, in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, ".handshake"}, out_valid, 0);
   endtask

   initial begin
      logic [31:0] iv;
      int          seen;
      v_m = V_REST_I; cnt_m = 0; spk_m = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst.v_out", v_out, 32'h8041_0000);
      chk("rst.spike", spike, 0);
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.refrac", refrac, 0);
      @(negedge clk);
      reset = 1'b0;

      run_step(32'h0000_0000, 0, "t2_rest");
      chk("t2.const", v_out, 32'h8041_0000);
      run_step(32'h0002_0000, 0, "t3_a");
      chk("t3a.const", v_out, 32'h803F_0000);
      run_step(32'h0002_0000, 0, "t3_b");
      chk("t3b.const", v_out, 32'h803E_0000);

      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      v_m = V_REST_I; cnt_m = 0;
      run_step(32'h0014_0000, 0, "t4_spike");
      chk("t4.const", {spike, refrac, v_out[30:0]}, {2'b11, 31'h004B_0000});
      run_step(32'h0014_0000, 0, "t5_ref1");
      chk("t5a.refrac", refrac, 1);
      run_step(32'h0014_0000, 0, "t5_ref2");
      chk("t5b.refrac", refrac, 0);
      run_step(32'h0014_0000, 0, "t5_eq_th");
      chk("t5c.spike", spike, 1);

      // reset while INTEG holds an in-flight sample
      @(negedge clk);
      in_valid = 1'b1;
      i_in     = 32'h0014_0000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst_mid.v_out", v_out, 32'h8041_0000);
      chk("rst_mid.spike", spike, 0);
      chk("rst_mid.out_valid", out_valid, 0);
      chk("rst_mid.in_ready", in_ready, 1);
      chk("rst_mid.refrac", refrac, 0);
      @(negedge clk);
      reset = 1'b0;
      v_m = V_REST_I; cnt_m = 0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("rst_mid.no_output", seen, 0);

      run_step(32'h0002_0000, 5, "t6_stall");
      run_step(32'h0014_0000, 5, "t6_stall_spike");

      for (int n = 0; n < 40; n++) begin
         iv = {($urandom_range(0, 3) == 0), 31'($urandom_range(0, 25 * 65536))};
         run_step(iv, $urandom_range(0, 3), $sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
